mem_ctl_seq: RTL and testbench

Sequencer and arbiter for the single-port memory controller. It accepts write requests on the din channel and read requests on the rd channel, arbitrates between them, and drives the memory bus through a fixed SETUP / STROBE / HOLD sequence with an anti-glitch guard phase. It completes each transaction with a one-cycle din_ack or dout_valid pulse. All outputs are registered and feed the memory bus and the client handshakes directly.

---
 rtl/mem_ctl_pkg.sv | 30 +++
 rtl/mem_ctl_seq_if.sv | 36 +++
 rtl/mem_ctl_rr_arb.sv | 29 ++
 rtl/mem_ctl_seq.sv | 131 +++++++++++++
 tb/tb_mem_ctl_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctl_pkg.sv
// Shared types and constants for the single-port memory controller sequencer.
// Holds the FSM state encoding, the op encoding and the strobe-width limits.
package mem_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  // Counter preload for a given strobe width; out-of-range widths are clamped.
  function automatic logic [CNT_W-1:0] wait_load(input int cycles);
    int c;
    c = cycles;
    if (c < WAIT_MIN) c = WAIT_MIN;
    if (c > WAIT_MAX) c = WAIT_MAX;
    return CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/mem_ctl_seq_if.sv
// Client handshake and memory bus bundle for mem_ctl_seq.
// The slave side is the controller; the master side is the client plus memory.
interface mem_ctl_seq_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic          din_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] din;
  logic          din_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_write;
  logic          mem_read;
  logic          anti_glitch;
  logic          busy;

  modport master (
    output din_valid, wr_addr, din, rd_req, rd_addr, mem_rdata,
    input  din_ack, dout, dout_valid, mem_addr, mem_wdata,
           mem_write, mem_read, anti_glitch, busy
  );

  modport slave (
    input  din_valid, wr_addr, din, rd_req, rd_addr, mem_rdata,
    output din_ack, dout, dout_valid, mem_addr, mem_wdata,
           mem_write, mem_read, anti_glitch, busy
  );

endinterface

// File: rtl/mem_ctl_rr_arb.sv
// Two-requester round-robin arbiter: on a tie the channel not served last wins.
// The last-served flag resets to "read" so the write channel wins the first tie.
module mem_ctl_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req_wr,
  input  logic req_rd,
  input  logic update,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic last_rd_q;

  always_comb begin
    gnt_wr = req_wr & (~req_rd | last_rd_q);
    gnt_rd = req_rd & (~req_wr | ~last_rd_q);
  end

  // Remember who was served only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd_q <= 1'b1;
    end else if (update && (gnt_wr || gnt_rd)) begin
      last_rd_q <= gnt_rd;
    end
  end

endmodule

// File: rtl/mem_ctl_seq.sv
// Sequencer for the single-port memory controller: arbitrates write/read requests
// and runs each through SETUP / STROBE / HOLD with fully registered outputs.
module mem_ctl_seq
  import mem_ctl_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  mem_ctl_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             grant;
  logic             din_elig, rd_elig;
  logic             gnt_wr, gnt_rd;

  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;
  logic [DW-1:0]    dout_q;
  logic             din_ack_q, dout_valid_q;
  logic             mem_write_q, mem_read_q;
  logic             anti_glitch_q, busy_q;

  // A channel whose completion pulse is showing is about to drop its request.
  assign din_elig = bus.din_valid & ~din_ack_q;
  assign rd_elig  = bus.rd_req & ~dout_valid_q;

  mem_ctl_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_wr (din_elig),
    .req_rd (rd_elig),
    .update (state_q == IDLE),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_wr || gnt_rd) begin
          grant   = 1'b1;
          op_d    = gnt_rd ? OP_RD : OP_WR;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wait_d  = WAIT_LOAD;
        state_d = STROBE;
      end
      STROBE: begin
        if (wait_q == '0) begin
          state_d = HOLD;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_WR;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs decode the next state so each one is a plain flop on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      dout_q        <= '0;
      din_ack_q     <= 1'b0;
      dout_valid_q  <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      anti_glitch_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      if (grant) begin
        mem_addr_q <= gnt_rd ? bus.rd_addr : bus.wr_addr;
        if (gnt_wr) begin
          mem_wdata_q <= bus.din;
        end
      end
      if (state_q == STROBE && wait_q == '0 && op_q == OP_RD) begin
        dout_q <= bus.mem_rdata;
      end
      mem_write_q   <= (state_d == STROBE) && (op_d == OP_WR);
      mem_read_q    <= (state_d == STROBE) && (op_d == OP_RD);
      anti_glitch_q <= (state_d == SETUP) || (state_d == HOLD);
      busy_q        <= (state_d != IDLE);
      din_ack_q     <= (state_q == HOLD) && (op_q == OP_WR);
      dout_valid_q  <= (state_q == HOLD) && (op_q == OP_RD);
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.dout        = dout_q;
  assign bus.din_ack     = din_ack_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.anti_glitch = anti_glitch_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_ctl_seq.sv
// Bench for mem_ctl_seq: three instances (WAIT_CYCLES 2, 1, 15) driven by directed
// vectors; a scoreboard queue holds expected completions, popped by a monitor.
module tb_mem_ctl_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       din_valid [3];
  logic [7:0] wr_addr   [3];
  logic [7:0] din       [3];
  logic       rd_req    [3];
  logic [7:0] rd_addr   [3];
  logic [7:0] mem_rdata [3];

  wire [2:0] ack_w, dv_w, mw_w, mr_w, ag_w, busy_w;
  wire [7:0] dout_w [3];
  wire [7:0] maddr_w [3];
  wire [7:0] mwdata_w [3];

  for (genvar g = 0; g < 3; g++) begin : u
    mem_ctl_seq_if bus ();
    assign bus.din_valid = din_valid[g];
    assign bus.wr_addr   = wr_addr[g];
    assign bus.din       = din[g];
    assign bus.rd_req    = rd_req[g];
    assign bus.rd_addr   = rd_addr[g];
    assign bus.mem_rdata = mem_rdata[g];
    assign ack_w[g]      = bus.din_ack;
    assign dv_w[g]       = bus.dout_valid;
    assign mw_w[g]       = bus.mem_write;
    assign mr_w[g]       = bus.mem_read;
    assign ag_w[g]       = bus.anti_glitch;
    assign busy_w[g]     = bus.busy;
    assign dout_w[g]     = bus.dout;
    assign maddr_w[g]    = bus.mem_addr;
    assign mwdata_w[g]   = bus.mem_wdata;
    mem_ctl_seq #(.WAIT_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  typedef struct {
    int         unit;
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] prev_addr [3];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int un, input bit rd, input logic [7:0] addr, input logic [7:0] data);
    if (rd) begin
      rd_req[un]  = 1'b1;
      rd_addr[un] = addr;
    end else begin
      din_valid[un] = 1'b1;
      wr_addr[un]   = addr;
      din[un]       = data;
    end
  endtask

  task automatic expectResp(input int un, input bit rd, input logic [7:0] data, input int at);
    exp_t e;
    e.unit = un;
    e.rd   = rd;
    e.data = data;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic checkIdle(input string name, input int un);
    checkOutput({name, "_flags"}, 8'({ack_w[un], dv_w[un], mw_w[un], mr_w[un], ag_w[un], busy_w[un]}), 8'h00);
    checkOutput({name, "_addr"}, maddr_w[un], 8'h00);
    checkOutput({name, "_wdata"}, mwdata_w[un], 8'h00);
    checkOutput({name, "_dout"}, dout_w[un], 8'h00);
  endtask

  // Measures strobe width and request-to-completion latency on one instance.
  task automatic runTiming(input int un, input bit rd, input int width, input int lat);
    int c, n, got;
    @(negedge clk);
    c = cyc;
    applyStimulus(un, rd, 8'h20, 8'h90);
    expectResp(un, rd, 8'h3C, c + lat);
    n   = 0;
    got = -1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (rd ? mr_w[un] : mw_w[un]) n++;
      if ((rd ? dv_w[un] : ack_w[un]) && got < 0) begin
        got = k;
        if (rd) rd_req[un] = 1'b0;
        else din_valid[un] = 1'b0;
      end
    end
    checkOutput($sformatf("strobe_width_u%0d", un), 8'(n), 8'(width));
    checkOutput($sformatf("latency_u%0d", un), 8'(got), 8'(lat));
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        total++;
        if (mw_w[i] & mr_w[i]) begin
          bad++;
          $display("[TB] FAIL strobe_excl u%0d: write=%b read=%b at cycle %0d", i, mw_w[i], mr_w[i], cyc);
        end
        if (mw_w[i] | mr_w[i]) begin
          total++;
          if (maddr_w[i] !== prev_addr[i]) begin
            bad++;
            $display("[TB] FAIL addr_stable u%0d: got %h expected %h at cycle %0d", i, maddr_w[i], prev_addr[i], cyc);
          end
        end
        if (ack_w[i] | dv_w[i]) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL sb_unexpected u%0d: ack=%b valid=%b with nothing expected at cycle %0d", i, ack_w[i], dv_w[i], cyc);
          end else begin
            e = sb.pop_front();
            if (e.unit != i || e.rd != dv_w[i] || e.cyc != cyc || (e.rd && dout_w[i] !== e.data)) begin
              bad++;
              $display("[TB] FAIL sb_resp: got u%0d rd=%b cyc=%0d dout=%h expected u%0d rd=%b cyc=%0d dout=%h",
                       i, dv_w[i], cyc, dout_w[i], e.unit, e.rd, e.cyc, e.data);
            end
          end
        end
      end
      prev_addr[i] = maddr_w[i];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    for (int i = 0; i < 3; i++) begin
      din_valid[i] = 1'b0;
      wr_addr[i]   = 8'h00;
      din[i]       = 8'h00;
      rd_req[i]    = 1'b0;
      rd_addr[i]   = 8'h00;
      mem_rdata[i] = 8'hEE;
      prev_addr[i] = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) checkIdle($sformatf("reset_u%0d", i), i);
    rst = 1'b0;

    // Single write, WAIT_CYCLES=2
    @(negedge clk);
    c = cyc;
    applyStimulus(0, 1'b0, 8'h12, 8'hA5);
    expectResp(0, 1'b0, 8'h00, c + 5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checkOutput("wr_ag", 8'(ag_w[0]), 8'(k == 1 || k == 4));
      checkOutput("wr_mw", 8'(mw_w[0]), 8'(k == 2 || k == 3));
      checkOutput("wr_ack", 8'(ack_w[0]), 8'(k == 5));
      checkOutput("wr_busy", 8'(busy_w[0]), 8'(k <= 4));
      if (k == 2 || k == 3) begin
        checkOutput("wr_addr", maddr_w[0], 8'h12);
        checkOutput("wr_data", mwdata_w[0], 8'hA5);
      end
      if (k == 5) din_valid[0] = 1'b0;
    end

    // Single read; memory data is only correct during STROBE
    @(negedge clk);
    c = cyc;
    applyStimulus(0, 1'b1, 8'h34, 8'h00);
    expectResp(0, 1'b1, 8'h5C, c + 5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      mem_rdata[0] = (k == 2 || k == 3) ? 8'h5C : 8'hEE;
      checkOutput("rd_mr", 8'(mr_w[0]), 8'(k == 2 || k == 3));
      checkOutput("rd_mw", 8'(mw_w[0]), 8'h00);
      checkOutput("rd_ag", 8'(ag_w[0]), 8'(k == 1 || k == 4));
      checkOutput("rd_dv", 8'(dv_w[0]), 8'(k == 5));
      if (k == 2 || k == 3) checkOutput("rd_addr", maddr_w[0], 8'h34);
      if (k >= 5) checkOutput("rd_dout", dout_w[0], 8'h5C);
      if (k == 5) rd_req[0] = 1'b0;
    end

    // Reset in the first STROBE cycle of a write
    @(negedge clk);
    c = cyc;
    applyStimulus(0, 1'b0, 8'h56, 8'h78);
    repeat (2) @(negedge clk);
    checkOutput("rst_pre_mw", 8'(mw_w[0]), 8'h01);
    rst = 1'b1;
    din_valid[0] = 1'b0;
    @(negedge clk);
    checkIdle("rst_mid", 0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("rst_noack", 8'(ack_w[0]), 8'h00);
    end

    // Both channels held high: write first, then alternate at a 5-cycle pitch
    @(negedge clk);
    c = cyc;
    mem_rdata[0] = 8'h77;
    applyStimulus(0, 1'b0, 8'h40, 8'h11);
    applyStimulus(0, 1'b1, 8'h41, 8'h00);
    expectResp(0, 1'b0, 8'h00, c + 5);
    expectResp(0, 1'b1, 8'h77, c + 10);
    expectResp(0, 1'b0, 8'h00, c + 15);
    expectResp(0, 1'b1, 8'h77, c + 20);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("alt_wr_addr", maddr_w[0], 8'h40);
      if (k == 6) begin
        checkOutput("alt_rd_addr", maddr_w[0], 8'h41);
        checkOutput("alt_rd_setup", 8'(ag_w[0]), 8'h01);
      end
      if (k == 11) checkOutput("alt_wr2_addr", maddr_w[0], 8'h40);
      if (k == 15) din_valid[0] = 1'b0;
      if (k == 20) rd_req[0] = 1'b0;
    end

    // Strobe-width extremes
    mem_rdata[2] = 8'h3C;
    runTiming(1, 1'b0, 1, 4);
    runTiming(2, 1'b1, 15, 18);

    repeat (3) @(negedge clk);
    checkOutput("sb_leftover", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
